// File: rtl/frame_buffer_writer_pkg.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer_pkg
//
// Shared definitions for the frame buffer writer and its frame store:
//   - default pixel width and active video geometry
//   - frame size helper (FRAME_WORDS = H_ACTIVE * V_ACTIVE)
//   - write FSM state encoding
//   - RGB444 field positions inside a pixel word
// -----------------------------------------------------------------------------
package frame_buffer_writer_pkg;

    // Pixel format: [3:0] R, [7:4] G, [11:8] B
    localparam int DEF_PIX_W    = 12;
    localparam int RGB_CH_W     = 4;
    localparam int RGB_R_LSB    = 0;
    localparam int RGB_G_LSB    = 4;
    localparam int RGB_B_LSB    = 8;

    // Default 640x480 active area
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_CNT_W    = 16;

    // Write FSM states
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,   // accepting, discarding beats until a start of frame
        WRITE    = 2'd1,   // filling the back bank
        FULL     = 2'd2    // back bank complete, holding off the source until a swap
    } wrState_t;

    // Number of pixel words in one frame.
    function automatic int frameWords(input int hActive, input int vActive);
        return hActive * vActive;
    endfunction

    // Assemble an RGB444 pixel word from its three channels.
    function automatic logic [DEF_PIX_W-1:0] rgbPack(input logic [RGB_CH_W-1:0] r,
                                                      input logic [RGB_CH_W-1:0] g,
                                                      input logic [RGB_CH_W-1:0] b);
        logic [DEF_PIX_W-1:0] pix;
        pix = '0;
        pix[RGB_R_LSB +: RGB_CH_W] = r;
        pix[RGB_G_LSB +: RGB_CH_W] = g;
        pix[RGB_B_LSB +: RGB_CH_W] = b;
        return pix;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// -----------------------------------------------------------------------------
// fb_dpram
//
// Simple dual-port RAM holding both frame banks. The caller forms a bank-major
// linear index (bank 0 in the lower FRAME_WORDS words, bank 1 in the upper
// FRAME_WORDS words), so the bank select acts as the most significant part of
// the address. One write port, one registered read port, no reset on the
// array or the read register so the block maps onto block RAM.
//
// Ports:
//   clk     in   clock, rising edge
//   wrEn    in   write strobe
//   wrAddr  in   write index
//   wrData  in   write data
//   rdAddr  in   read index
//   rdData  out  registered read data, 1-cycle latency
// -----------------------------------------------------------------------------
module fb_dpram
    import frame_buffer_writer_pkg::*;
#(
    parameter int DATA_W = DEF_PIX_W,
    parameter int DEPTH  = 2 * DEF_H_ACTIVE * DEF_V_ACTIVE,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [AW-1:0]     rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// -----------------------------------------------------------------------------
// frame_buffer_writer
//
// Writes an RGB444 pixel stream into a double-buffered frame store and serves
// the scan-out stage's pixel reads from the displayed bank. Frames are written
// only into the back bank; the banks swap on a falling vsync_n edge once the
// back bank holds a complete frame, so a displayed frame never tears.
//
// Ports:
//   clk            in   pixel clock, rising edge
//   rst            in   asynchronous active-high reset
//   s_data         in   input pixel (RGB444)
//   s_valid        in   s_data valid
//   s_sof          in   start-of-frame marker, qualified by s_valid
//   s_ready        out  writer can accept a beat
//   rd_addr        in   scan-out read address, line*H_ACTIVE + pixel
//   rd_data        out  pixel at rd_addr in the front bank, 1-cycle latency
//   vsync_n        in   vertical sync from scan-out, active low
//   front_bank     out  bank currently displayed
//   frame_pending  out  back bank holds a complete, undisplayed frame
//   sof_err        out  sticky: SOF arrived mid-frame
//   drop_err       out  sticky: beat dropped while waiting for SOF
//   frame_cnt      out  number of bank swaps, wraps
// -----------------------------------------------------------------------------
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              vsync_n,
    output logic              front_bank,
    output logic              frame_pending,
    output logic              sof_err,
    output logic              drop_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int FRAME_WORDS = frameWords(H_ACTIVE, V_ACTIVE);
    localparam int MEM_DEPTH   = 2 * FRAME_WORDS;
    localparam int MEM_AW      = $clog2(MEM_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    // One extra bit so the first out-of-range address is representable.
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_WORDS);

    // The address space must cover a frame plus the parking address, and a
    // frame must have at least two words for the SOF/last-beat logic to work.
    if ((64'd1 << ADDR_W) <= 64'(FRAME_WORDS)) begin : gAddrWidthCheck
        $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE plus the parking address");
    end
    if (FRAME_WORDS < 2) begin : gFrameSizeCheck
        $error("frame must contain at least two pixels");
    end

    // Bank-major index into the two-bank store.
    function automatic logic [MEM_AW-1:0] memIndex(input logic bank,
                                                   input logic [ADDR_W-1:0] addr);
        return MEM_AW'(addr) + (bank ? MEM_AW'(FRAME_WORDS) : '0);
    endfunction

    wrState_t            state;
    logic [ADDR_W-1:0]   wrAddr;
    logic                vsyncD;

    logic                accept;
    logic                vsyncFall;
    logic                swapFire;
    logic                wrEn;
    logic [ADDR_W-1:0]   wrAddrSel;
    logic [MEM_AW-1:0]   wrIdx;

    logic                rdInRange;
    logic [MEM_AW-1:0]   rdIdx;
    logic                rdVld_p0;
    logic [PIX_W-1:0]    ramQ_p0;

    assign accept    = s_valid && s_ready;
    assign vsyncFall = vsyncD && !vsync_n;
    // Uses the registered frame_pending, so a frame completing on the same
    // edge as the vsync fall waits for the next fall.
    assign swapFire  = vsyncFall && frame_pending;

    // An SOF beat always lands at word 0, whether it opens a frame or
    // restarts one mid-stream. Non-SOF beats are stored only while writing.
    assign wrEn      = accept && (s_sof || (state == WRITE));
    assign wrAddrSel = s_sof ? '0 : wrAddr;
    assign wrIdx     = memIndex(~front_bank, wrAddrSel);

    // Write FSM: s_ready is registered and follows the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_SOF;
            wrAddr        <= '0;
            s_ready       <= 1'b0;
            frame_pending <= 1'b0;
            sof_err       <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            unique case (state)
                WAIT_SOF: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (s_sof) begin
                            wrAddr <= ADDR_W'(1);
                            state  <= WRITE;
                        end else begin
                            drop_err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (s_sof) begin
                            sof_err <= 1'b1;
                            wrAddr  <= ADDR_W'(1);
                        end else if (wrAddr == LAST_ADDR) begin
                            state         <= FULL;
                            frame_pending <= 1'b1;
                            s_ready       <= 1'b0;
                            wrAddr        <= '0;
                        end else begin
                            wrAddr <= wrAddr + ADDR_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (swapFire) begin
                        state         <= WAIT_SOF;
                        frame_pending <= 1'b0;
                        s_ready       <= 1'b1;
                    end
                end
                default: begin
                    state   <= WAIT_SOF;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bank swap on the vsync falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsyncD     <= 1'b1;
            front_bank <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsyncD <= vsync_n;
            if (swapFire) begin
                front_bank <= ~front_bank;
                frame_cnt  <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Read request stage: out-of-range addresses read word 0 harmlessly and
    // are forced to zero on the way out.
    assign rdInRange = ({1'b0, rd_addr} < FRAME_END);
    assign rdIdx     = memIndex(front_bank, rdInRange ? rd_addr : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdVld_p0 <= 1'b0;
        end else begin
            rdVld_p0 <= rdInRange;
        end
    end

    fb_dpram #(
        .DATA_W (PIX_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (MEM_AW)
    ) uStore (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrIdx),
        .wrData (s_data),
        .rdAddr (rdIdx),
        .rdData (ramQ_p0)
    );

    // Read output stage: rdVld_p0 clears on reset, so rd_data reads 0 while
    // the unreset RAM register still holds stale contents.
    assign rd_data = rdVld_p0 ? ramQ_p0 : '0;

endmodule
